// File: rtl/vga_scan_gen.sv
// Raster scan generator for the VGA output path: pixel-rate divider, horizontal/vertical
// counters, registered sync/visible decodes and frame strobes for the sprite drawers.
module vga_scan_gen #(
    parameter int PIX_DIV = 4,
    parameter int H_VIS   = 640,
    parameter int H_FP    = 16,
    parameter int H_SYNC  = 96,
    parameter int H_BP    = 48,
    parameter int V_VIS   = 480,
    parameter int V_FP    = 10,
    parameter int V_SYNC  = 2,
    parameter int V_BP    = 33
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        run,
    output logic [9:0]  horCnt,
    output logic [9:0]  verCnt,
    output logic        hsync,
    output logic        vsync,
    output logic        videoOn,
    output logic        pixTick,
    output logic        frameTick,
    output logic [15:0] frameCnt
);

    localparam int DIV_W = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PIX_DIV - 1);

    // Timing boundaries are formed at 11 bits so the parameter sums cannot overflow.
    localparam logic [10:0] H_LAST       = 11'(H_VIS + H_FP + H_SYNC + H_BP - 1);
    localparam logic [10:0] V_LAST       = 11'(V_VIS + V_FP + V_SYNC + V_BP - 1);
    localparam logic [10:0] H_VIS_END    = 11'(H_VIS);
    localparam logic [10:0] V_VIS_END    = 11'(V_VIS);
    localparam logic [10:0] H_SYNC_FIRST = 11'(H_VIS + H_FP);
    localparam logic [10:0] H_SYNC_LAST  = 11'(H_VIS + H_FP + H_SYNC - 1);
    localparam logic [10:0] V_SYNC_FIRST = 11'(V_VIS + V_FP);
    localparam logic [10:0] V_SYNC_LAST  = 11'(V_VIS + V_FP + V_SYNC - 1);

    logic [DIV_W-1:0] div_cnt;
    logic             tick_q;
    logic [9:0]       hor_next;
    logic [9:0]       ver_next;
    logic [15:0]      frame_next;
    logic             frame_wrap;
    logic [10:0]      hor_wide;
    logic [10:0]      ver_wide;
    logic             hsync_next;
    logic             vsync_next;
    logic             video_next;

    // Gating with run lets a falling run cancel a pending advance in the same cycle.
    assign pixTick = tick_q & run;

    always_comb begin
        hor_next   = horCnt;
        ver_next   = verCnt;
        frame_next = frameCnt;
        frame_wrap = 1'b0;
        if (pixTick) begin
            if ({1'b0, horCnt} == H_LAST) begin
                hor_next = 10'd0;
                if ({1'b0, verCnt} == V_LAST) begin
                    ver_next   = 10'd0;
                    frame_next = frameCnt + 16'd1;
                    frame_wrap = 1'b1;
                end else begin
                    ver_next = verCnt + 10'd1;
                end
            end else begin
                hor_next = horCnt + 10'd1;
            end
        end
    end

    // Decoding the next-state coordinates keeps the registered syncs aligned with the counters.
    always_comb begin
        hor_wide   = {1'b0, hor_next};
        ver_wide   = {1'b0, ver_next};
        hsync_next = 1'b1;
        vsync_next = 1'b1;
        video_next = 1'b0;
        if (run) begin
            hsync_next = !((hor_wide >= H_SYNC_FIRST) && (hor_wide <= H_SYNC_LAST));
            vsync_next = !((ver_wide >= V_SYNC_FIRST) && (ver_wide <= V_SYNC_LAST));
            video_next = (hor_wide < H_VIS_END) && (ver_wide < V_VIS_END);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
            tick_q  <= 1'b0;
        end else if (!run) begin
            div_cnt <= '0;
            tick_q  <= 1'b0;
        end else begin
            tick_q  <= (div_cnt == DIV_LAST);
            div_cnt <= (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            horCnt    <= 10'd0;
            verCnt    <= 10'd0;
            frameCnt  <= 16'd0;
            hsync     <= 1'b1;
            vsync     <= 1'b1;
            videoOn   <= 1'b0;
            frameTick <= 1'b0;
        end else begin
            horCnt    <= hor_next;
            verCnt    <= ver_next;
            frameCnt  <= frame_next;
            hsync     <= hsync_next;
            vsync     <= vsync_next;
            videoOn   <= video_next;
            frameTick <= frame_wrap;
        end
    end

endmodule

// File: doc/vga_scan_gen.md
# vga_scan_gen

Raster scan generator for the 640x480@60 Hz VGA output path. It produces the `horCnt`/`verCnt` pixel coordinates consumed by the sprite draw-enable logic (enemy, player and bullet drawers), along with `hsync`, `vsync`, the visible-area flag and frame/pixel strobes. It runs from the 100 MHz system clock and uses an internal pixel-rate divider. Every downstream drawer is combinational on its outputs.

## Interface

**Parameters**

- `PIX_DIV`, 4: system clocks per pixel.
- `H_VIS`, 640: visible pixels per line.
- `H_FP`, 16: horizontal front porch.
- `H_SYNC`, 96: horizontal sync width.
- `H_BP`, 48: horizontal back porch.
- `V_VIS`, 480: visible lines.
- `V_FP`, 10: vertical front porch.
- `V_SYNC`, 2: vertical sync width.
- `V_BP`, 33: vertical back porch.

**Ports**

- `clk` (input, 1): 100 MHz system clock.
- `rst_n` (input, 1): asynchronous, active-low reset.
- `run` (input, 1): scan enable; when low, the scan freezes.
- `horCnt` (output, 10): current pixel column, 0..H_TOTAL-1.
- `verCnt` (output, 10): current line, 0..V_TOTAL-1.
- `hsync` (output, 1): horizontal sync, active low.
- `vsync` (output, 1): vertical sync, active low.
- `videoOn` (output, 1): high when the current coordinate is in the visible area.
- `pixTick` (output, 1): one-clock strobe; the coordinates advance on the next edge.
- `frameTick` (output, 1): one-clock pulse when the scan wraps to (0,0).
- `frameCnt` (output, 16): frame counter, wraps modulo 2^16.

## Operation

- Derived totals: H_TOTAL = H_VIS+H_FP+H_SYNC+H_BP (800); V_TOTAL = V_VIS+V_FP+V_SYNC+V_BP (525).
- **Divider:** `divCnt` counts 0..PIX_DIV-1 while `run`=1. `pixTick` = (`divCnt`==PIX_DIV-1) && `run`, decoded from registers.
- **Pixel advance:** on an edge where `pixTick`=1:
  - `horCnt` increments, or wraps to 0 from H_TOTAL-1.
  - On that wrap, `verCnt` increments, or wraps to 0 from V_TOTAL-1.
  - On the joint wrap, `frameCnt` increments.
- **Registered decodes:** `hsync`, `vsync` and `videoOn` are registered from the next-state counter values, so they are cycle-aligned with `horCnt`/`verCnt` and never lag by a cycle.
  - `hsync`=0 iff `horCnt` is in [H_VIS+H_FP, H_VIS+H_FP+H_SYNC-1], i.e. [656,751].
  - `vsync`=0 iff `verCnt` is in [V_VIS+V_FP, V_VIS+V_FP+V_SYNC-1], i.e. [490,491].
  - `videoOn`=1 iff `horCnt`<H_VIS && `verCnt`<V_VIS && `run`.
- **frameTick:** registered. It is high for exactly one clock: the clock in which `horCnt`=0 and `verCnt`=0 first appear after a wrap. It does not fire at reset or on `run` resume.
- **run=0 (freeze):**
  - `divCnt` is cleared to 0.
  - `horCnt`, `verCnt` and `frameCnt` hold their values.
  - `hsync`=`vsync`=1, `videoOn`=0, `pixTick`=0.
- **run 0→1 (resume):** on the next edge, the decodes again reflect the held counters. The first `pixTick` arrives PIX_DIV clocks after `run` is sampled high.
- **Reset values** (asynchronous, applied immediately on `rst_n`=0): `divCnt`=0, `horCnt`=0, `verCnt`=0, `frameCnt`=0, `hsync`=1, `vsync`=1, `videoOn`=0, `pixTick`=0, `frameTick`=0. This holds even mid-line or mid-sync.
- **Arithmetic:** all counters are unsigned. Compares use the parameter sums computed at elevation width 11 to avoid overflow, then compare against the 10-bit counters.

## Timing

- **Latency:** one clock from `run` sampled high to valid decodes. No other pipeline stages.
- **Pixel period:** PIX_DIV clocks. With defaults:
  - line period = 3200 clocks;
  - frame period = 1,680,000 clocks (59.52 Hz).
- **Stability:** `horCnt`/`verCnt` change only on the edge following `pixTick`, and remain stable for PIX_DIV clocks. Downstream combinational draw-enables therefore have PIX_DIV-1 cycles of settling margin.
- **Reset release:** the first `pixTick` occurs PIX_DIV clocks after the first edge with `rst_n`=1 and `run`=1.
- **Simultaneous events:** for the `pixTick` that wraps both counters, `horCnt`, `verCnt`, `frameCnt` and `frameTick` all update on the same edge.
- **run vs pixTick:** if `run` falls in the same cycle that `pixTick` would fire, `run` wins and the counters hold.

## Test plan

- **Reset:** assert `rst_n`=0 mid-line at (300,200) → within the same cycle all counters read 0, `hsync`=`vsync`=1, `videoOn`=0. Release with `run`=1 → `pixTick` pulses every 4th clock; `horCnt` reads 1 after the first pulse.
- **Line wrap:** step to `horCnt`=799, `verCnt`=10 → the next pixel is (0,11). `hsync` is low for exactly 96 consecutive pixels (656..751) = 384 clocks.
- **Vertical sync / visible area:** over one frame, `vsync` is low only on lines 490 and 491 (1600 pixels). `videoOn` is high for exactly 640x480 = 307,200 pixels.
- **Frame wrap:** at (799,524) plus `pixTick` → (0,0), `frameTick` high for one clock, `frameCnt` 0→1. Consecutive `frameTick` pulses are 1,680,000 clocks apart.
- **Freeze:** drop `run` at (100,50) → counters hold at (100,50) for 1000 clocks, `videoOn`=0, syncs high, no `pixTick`. Raise `run` → `videoOn`=1 after one clock; `horCnt`=101 after 4 more clocks.
- **frameCnt wrap:** force `frameCnt`=65535 near end of frame → it wraps to 0 together with `frameTick`.
